// File: rtl/game_input_pkg.sv
// game_input_pkg: shared parser states, key indices, command codes and PS/2 scan codes
package game_input_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} parse_state_t;
  localparam int K_SPACE = 0;
  localparam int K_UP    = 1;
  localparam int K_DOWN  = 2;
  localparam int K_ENTER = 3;
  localparam logic [1:0] CMD_START    = 2'd0;
  localparam logic [1:0] CMD_JUMP     = 2'd1;
  localparam logic [1:0] CMD_DUCK_ON  = 2'd2;
  localparam logic [1:0] CMD_DUCK_OFF = 2'd3;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  function automatic logic is_status(input logic [7:0] b);
    return b == SC_ACK || b == SC_BAT || b == SC_ECHO || b == SC_RESEND;
  endfunction
endpackage

// File: rtl/ps2_scan_parser.sv
// ps2_scan_parser: make/break/extended scan-code FSM with one-cycle event strobe; PREFIX_TIMEOUT_EN adds a prefix timeout
module ps2_scan_parser
  import game_input_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int TIMEOUT_US      = 2000
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       is_make,
  output logic       is_break,
  output logic       ext,
  output logic [7:0] code
);
  localparam int TIMEOUT_CYCLES = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("prefix timeout must be at least one clock cycle");
  end
  parse_state_t state;
  logic timed_out;
  // strobe is decoded from the byte in flight so key state updates on the same edge
  assign is_make  = rx_valid && ((state == ST_IDLE && rx_data != SC_EXT && rx_data != SC_BRK && !is_status(rx_data)) ||
                                 (state == ST_EXT && rx_data != SC_BRK));
  assign is_break = rx_valid && (state == ST_BRK || state == ST_EXT_BRK);
  assign ext      = state == ST_EXT || state == ST_EXT_BRK;
  assign code     = rx_data;
`ifdef PREFIX_TIMEOUT_EN
  logic [31:0] idle_cnt;
  assign timed_out = state != ST_IDLE && !rx_valid && idle_cnt == TIMEOUT_CYCLES - 1;
  // counts silent cycles while a prefix is outstanding
  always_ff @(posedge Clock or posedge reset)
    if (reset) idle_cnt <= '0;
    else idle_cnt <= (clear || rx_valid || state == ST_IDLE || timed_out) ? '0 : idle_cnt + 32'd1;
`else
  assign timed_out = 1'b0;
`endif
  // prefix tracking; every non-prefix byte returns to IDLE
  always_ff @(posedge Clock or posedge reset)
    if (reset) state <= ST_IDLE;
    else if (clear || timed_out) state <= ST_IDLE;
    else if (rx_valid)
      state <= state == ST_IDLE ? (rx_data == SC_EXT ? ST_EXT : rx_data == SC_BRK ? ST_BRK : ST_IDLE) :
               (state == ST_EXT && rx_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
endmodule

// File: rtl/game_input_controller.sv
// game_input_controller: PS/2 key tracking and prioritised game command port; PREFIX_TIMEOUT_EN enables parser prefix timeout
module game_input_controller
  import game_input_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int TIMEOUT_US      = 2000
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output logic [3:0] key_held,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  input  logic       cmd_ready
);
  logic       is_make, is_break, ext;
  logic [7:0] code;
  logic [3:0] hit, press, rel, pend, grant, kept, pend_nx;
  ps2_scan_parser #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY), .TIMEOUT_US(TIMEOUT_US)) u_parser (
    .Clock(Clock), .reset(reset), .clear(clear), .rx_data(rx_data), .rx_valid(rx_valid),
    .is_make(is_make), .is_break(is_break), .ext(ext), .code(code)
  );
  assign hit[K_SPACE] = !ext && code == SC_SPACE;
  assign hit[K_UP]    = ext && code == SC_UP;
  assign hit[K_DOWN]  = ext && code == SC_DOWN;
  assign hit[K_ENTER] = !ext && code == SC_ENTER;
  assign press = {4{is_make}} & hit & ~key_held;
  assign rel   = {4{is_break}} & hit & key_held;
  assign cmd_valid = |pend;
  assign cmd_code  = pend[CMD_START] ? CMD_START : pend[CMD_JUMP] ? CMD_JUMP :
                     pend[CMD_DUCK_ON] ? CMD_DUCK_ON : pend[CMD_DUCK_OFF] ? CMD_DUCK_OFF : CMD_START;
  assign grant = (cmd_valid && cmd_ready) ? 4'b0001 << cmd_code : 4'b0000;
  assign kept  = pend & ~grant;
  assign pend_nx[CMD_START]    = kept[CMD_START] | press[K_ENTER];
  assign pend_nx[CMD_JUMP]     = kept[CMD_JUMP] | press[K_SPACE] | press[K_UP];
  assign pend_nx[CMD_DUCK_ON]  = press[K_DOWN] | (kept[CMD_DUCK_ON] & ~rel[K_DOWN]);
  assign pend_nx[CMD_DUCK_OFF] = rel[K_DOWN] | (kept[CMD_DUCK_OFF] & ~press[K_DOWN]);
  // held keys and pending commands; clear flushes everything
  always_ff @(posedge Clock or posedge reset)
    if (reset) begin
      key_held <= '0;
      pend     <= '0;
    end else if (clear) begin
      key_held <= '0;
      pend     <= '0;
    end else begin
      key_held <= (key_held | press) & ~rel;
      pend     <= pend_nx;
    end
endmodule
